// File: rtl/prime_checker_seq_pkg.sv
// Shared definitions for the sequential primality tester: FSM encoding and default operand width.
package prime_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCREEN = 3'd1,
    BOUND  = 3'd2,
    DIV    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/prime_checker_seq_mod_serial.sv
// Restoring-division remainder unit: one dividend bit per cycle, MSB first.
// The first bit is consumed on the load edge so the final remainder is valid in the WIDTH-th cycle after load.
module mod_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;

  // Partial remainder is always below the divisor, so {r, bit} fits in WIDTH+1 bits.
  function automatic logic [WIDTH-1:0] rstep(input logic [WIDTH-1:0] r,
                                             input logic             b,
                                             input logic [WIDTH-1:0] dv);
    logic [WIDTH:0] t;
    t = {r, b};
    if (t >= {1'b0, dv}) begin
      t = t - {1'b0, dv};
    end
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    rem_d   = rem_q;
    shift_d = shift_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (load) begin
      rem_d   = rstep('0, dividend[WIDTH-1], divisor);
      shift_d = dividend << 1;
      div_d   = divisor;
      cnt_d   = CW'(WIDTH - 1);
    end else if (cnt_q != '0) begin
      rem_d   = rstep(rem_q, shift_q[WIDTH-1], div_q);
      shift_d = shift_q << 1;
      cnt_d   = cnt_q - CW'(1);
      valid_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      shift_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign rem   = rem_q;
  assign valid = valid_q;

endmodule

// File: rtl/prime_checker_seq.sv
// Sequential primality tester: cheap screening, then odd trial divisors d=3,5,.. while d*d <= n.
module prime_checker_seq
  import prime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             is_prime
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic             is_prime_q, is_prime_d;

  logic             load;
  logic [WIDTH-1:0] rem;
  logic             rem_valid;

  // Full-width square so the bound test never wraps.
  logic [2*WIDTH-1:0] trial_ext, trial_sq, n_ext;
  logic               sq_gt;

  assign trial_ext = {{WIDTH{1'b0}}, trial_q};
  assign n_ext     = {{WIDTH{1'b0}}, n_q};
  assign trial_sq  = trial_ext * trial_ext;
  assign sq_gt     = (trial_sq > n_ext);

  mod_serial #(.WIDTH(WIDTH)) u_mod (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .dividend (n_q),
    .divisor  (trial_q),
    .rem      (rem),
    .valid    (rem_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      trial_q    <= '0;
      is_prime_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      trial_q    <= trial_d;
      is_prime_q <= is_prime_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    trial_d    = trial_q;
    is_prime_d = is_prime_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d        = n;
          is_prime_d = 1'b0;
          state_d    = SCREEN;
        end
      end
      SCREEN: begin
        if (n_q < WIDTH'(2)) begin
          is_prime_d = 1'b0;
          state_d    = DONE;
        end else if (n_q < WIDTH'(4)) begin
          is_prime_d = 1'b1;
          state_d    = DONE;
        end else if (!n_q[0]) begin
          is_prime_d = 1'b0;
          state_d    = DONE;
        end else begin
          trial_d = WIDTH'(3);
          state_d = BOUND;
        end
      end
      BOUND: begin
        if (sq_gt) begin
          is_prime_d = 1'b1;
          state_d    = DONE;
        end else begin
          state_d = DIV;
        end
      end
      DIV: begin
        if (rem_valid) begin
          if (rem == '0) begin
            is_prime_d = 1'b0;
            state_d    = DONE;
          end else begin
            trial_d = trial_q + WIDTH'(2);
            state_d = BOUND;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    busy  = (state_q != IDLE);
    done  = (state_q == DONE);
    load  = (state_q == BOUND) && !sq_gt;
  end

  assign is_prime = is_prime_q;

endmodule

// File: tb/tb_prime_checker_seq.sv
// Scoreboard bench for prime_checker_seq (WIDTH=8): driver pushes expectations, negedge monitor compares.
module tb_prime_checker_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] n;
  logic         ready, busy, done, is_prime;

  int edge_cnt = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int nval;
    bit exp_prime;
    int lat;
    int acc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] req;
  } chk_t;

  exp_t sbq[$];
  chk_t pend[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  prime_checker_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .is_prime (is_prime)
  );

  function automatic bit ref_prime(input int v);
    if (v < 2) return 1'b0;
    for (int i = 2; i * i <= v; i++) begin
      if (v % i == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int ref_lat(input int v);
    int k;
    if (v < 4 || v % 2 == 0) return 1;
    k = 0;
    for (int dv = 3; dv * dv <= v; dv += 2) begin
      k++;
      if (v % dv == 0) return 1 + k * (W + 1);
    end
    return 2 + k * (W + 1);
  endfunction

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  bit done_prev = 1'b0;
  bit last_verdict = 1'b0;

  always @(negedge clk) begin
    chk_t c;
    exp_t e;
    while (pend.size() > 0) begin
      c = pend.pop_front();
      check(c.name, c.act, c.req);
    end
    if (!rst) begin
      check("busy_eq_not_ready", {31'd0, busy}, {31'd0, ~ready});
      if (done) begin
        check("done_single_cycle", {31'd0, done_prev}, 32'd0);
        check("request_pending_at_done", {31'd0, sbq.size() > 0}, 32'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check($sformatf("verdict n=%0d", e.nval), {31'd0, is_prime}, {31'd0, e.exp_prime});
          check($sformatf("latency n=%0d", e.nval), edge_cnt - e.acc, e.lat);
          last_verdict = e.exp_prime;
        end
      end else if (done_prev) begin
        check("is_prime_held_after_done", {31'd0, is_prime}, {31'd0, last_verdict});
      end
    end
    done_prev = done;
  end

  // ---------------- driver ----------------
  task automatic issue(input int v, input bit ev, input int el);
    int t;
    t = 0;
    @(negedge clk);
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      pend.push_back('{"ready_timeout", 32'd0, 32'd1});
      return;
    end
    start = 1'b1;
    n     = W'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = W'($urandom);
    sbq.push_back('{v, ev, el, edge_cnt});
    pend.push_back('{"is_prime_cleared_on_accept", {31'd0, is_prime}, 32'd0});
  endtask

  task automatic push_reset_checks(input string tag);
    pend.push_back('{{tag, "_ready"},    {31'd0, ready},    32'd1});
    pend.push_back('{{tag, "_busy"},     {31'd0, busy},     32'd0});
    pend.push_back('{{tag, "_done"},     {31'd0, done},     32'd0});
    pend.push_back('{{tag, "_is_prime"}, {31'd0, is_prime}, 32'd0});
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sbq.size() > 0) begin
      pend.push_back('{"drain_timeout", 32'd0, 32'd1});
      sbq.delete();
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    n     = '0;
    #1 rst = 1'b1;
    #1 push_reset_checks("reset_before_clock");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // screened operands: L=1
    issue(0, 1'b0, 1);
    issue(1, 1'b0, 1);
    issue(2, 1'b1, 1);
    issue(3, 1'b1, 1);
    issue(4, 1'b0, 1);
    issue(200, 1'b0, 1);
    // trial division
    issue(9, 1'b0, 10);
    issue(5, 1'b1, 2);
    issue(251, 1'b1, 65);
    issue(221, 1'b0, 55);
    drain();

    // start while busy must be ignored
    issue(251, 1'b1, 65);
    repeat (10) @(negedge clk);
    pend.push_back('{"ready_low_while_busy", {31'd0, ready}, 32'd0});
    start = 1'b1;
    n     = 8'd4;
    @(negedge clk);
    start = 1'b0;
    drain();

    // back-to-back: each issue accepts on the first ready cycle
    issue(13, 1'b1, 2 + 1 * (W + 1));
    issue(15, 1'b0, 1 + 1 * (W + 1));
    issue(6, 1'b0, 1);
    drain();

    // asynchronous reset in the middle of a division
    issue(221, 1'b0, 55);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 push_reset_checks("reset_mid_div");
    sbq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(7, 1'b1, 2);
    drain();

    // exhaustive sweep against the reference model
    for (int v = 0; v < 256; v++) begin
      issue(v, ref_prime(v), ref_lat(v));
    end
    drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
